// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit: operand-select encodings
// and the bit layout of the MEM/WB register-tag slots.
package forwarding_hazard_unit_pkg;

    // Must match the select encoding of the EX-stage operand mux.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    // MEM/WB slot vector: {dest, regwrite, valid}, dest occupies the top bits.
    localparam int SLOT_VALID_BIT    = 0;
    localparam int SLOT_REGWRITE_BIT = 1;
    localparam int SLOT_DEST_LSB     = 2;

    function automatic int slot_width(input int reg_dir_width);
        return SLOT_DEST_LSB + reg_dir_width;
    endfunction

    // MEM holds the newer result, so it wins over WB.
    function automatic fwd_sel_t fwd_pick(input logic hit_mem, input logic hit_wb);
        fwd_sel_t sel;
        sel = FWD_REG;
        if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage decode inputs and operand-select / hazard outputs of the forwarding unit.
interface forwarding_hazard_unit_if
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int REG_DIR_WIDTH = 3,
    parameter int CNT_WIDTH     = 16
) ();

    logic                     id_valid;
    logic [REG_DIR_WIDTH-1:0] id_rs;
    logic [REG_DIR_WIDTH-1:0] id_rt;
    logic                     id_uses_rs;
    logic                     id_uses_rt;
    logic [REG_DIR_WIDTH-1:0] id_rd;
    logic                     id_regdst;
    logic                     id_regwrite;
    logic                     id_memread;
    logic                     flush;

    fwd_sel_t                 Forward_A;
    fwd_sel_t                 Forward_B;
    logic                     stall;
    logic                     bubble;
    logic [CNT_WIDTH-1:0]     stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regdst, id_regwrite, id_memread, flush,
        input  Forward_A, Forward_B, stall, bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regdst, id_regwrite, id_memread, flush,
        output Forward_A, Forward_B, stall, bubble, stall_count
    );

endinterface

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// Operand source select for one EX source register, from the MEM and WB tag slots.
module fwd_select
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int REG_DIR_WIDTH = 3
) (
    input  logic                                   src_used,
    input  logic [REG_DIR_WIDTH-1:0]               src_reg,
    input  logic [SLOT_DEST_LSB+REG_DIR_WIDTH-1:0] mem_slot,
    input  logic [SLOT_DEST_LSB+REG_DIR_WIDTH-1:0] wb_slot,
    output fwd_sel_t                               sel
);

    logic [REG_DIR_WIDTH-1:0] mem_dest;
    logic [REG_DIR_WIDTH-1:0] wb_dest;
    logic                     hit_mem;
    logic                     hit_wb;

    assign mem_dest = mem_slot[SLOT_DEST_LSB +: REG_DIR_WIDTH];
    assign wb_dest  = wb_slot[SLOT_DEST_LSB +: REG_DIR_WIDTH];

    // r0 is hardwired, so a write to it never produces a forwardable value.
    assign hit_mem = mem_slot[SLOT_VALID_BIT] & mem_slot[SLOT_REGWRITE_BIT]
                   & (mem_dest != '0) & (mem_dest == src_reg);
    assign hit_wb  = wb_slot[SLOT_VALID_BIT] & wb_slot[SLOT_REGWRITE_BIT]
                   & (wb_dest != '0) & (wb_dest == src_reg);

    assign sel = src_used ? fwd_pick(hit_mem, hit_wb) : FWD_REG;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit: shadow tag pipeline EX->MEM->WB,
// operand-select generation, stall/bubble and a saturating stall counter.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int REG_DIR_WIDTH = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    forwarding_hazard_unit_if.slave bus
);

    localparam int SLOT_W = slot_width(REG_DIR_WIDTH);

    logic                     ex_valid;
    logic [REG_DIR_WIDTH-1:0] ex_rs;
    logic [REG_DIR_WIDTH-1:0] ex_rt;
    logic                     ex_uses_rs;
    logic                     ex_uses_rt;
    logic [REG_DIR_WIDTH-1:0] ex_dest;
    logic                     ex_regwrite;
    logic                     ex_memread;

    logic [SLOT_W-1:0]        ex_slot;
    logic [SLOT_W-1:0]        mem_slot;
    logic [SLOT_W-1:0]        wb_slot;

    logic [REG_DIR_WIDTH-1:0] id_dest;
    logic                     ex_load_live;
    logic                     rs_dep;
    logic                     rt_dep;
    logic                     stall;
    logic                     bubble;
    logic [CNT_WIDTH-1:0]     stall_count_q;
    fwd_sel_t                 fwd_a;
    fwd_sel_t                 fwd_b;

    assign id_dest = bus.id_regdst ? bus.id_rd : bus.id_rt;

    always_comb begin
        ex_slot                                    = '0;
        ex_slot[SLOT_VALID_BIT]                    = ex_valid;
        ex_slot[SLOT_REGWRITE_BIT]                 = ex_regwrite;
        ex_slot[SLOT_DEST_LSB +: REG_DIR_WIDTH]    = ex_dest;
    end

    // A load in EX cannot supply its data until it reaches WB, so the reader waits one cycle.
    always_comb begin
        ex_load_live = ex_valid & ex_memread & ex_regwrite & (ex_dest != '0);
        rs_dep       = bus.id_uses_rs & (bus.id_rs == ex_dest);
        rt_dep       = bus.id_uses_rt & (bus.id_rt == ex_dest);
        stall        = bus.id_valid & ex_load_live & (rs_dep | rt_dep);
        bubble       = stall | bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_uses_rs  <= 1'b0;
            ex_uses_rt  <= 1'b0;
            ex_dest     <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            mem_slot    <= '0;
            wb_slot     <= '0;
        end else begin
            wb_slot     <= mem_slot;
            mem_slot    <= ex_slot;
            ex_valid    <= bus.id_valid & ~bubble;
            ex_rs       <= bus.id_rs;
            ex_rt       <= bus.id_rt;
            ex_uses_rs  <= bus.id_uses_rs;
            ex_uses_rt  <= bus.id_uses_rt;
            ex_dest     <= id_dest;
            ex_regwrite <= bus.id_regwrite;
            ex_memread  <= bus.id_memread;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_q <= stall_count_q + CNT_WIDTH'(1);
        end
    end

    fwd_select #(
        .REG_DIR_WIDTH (REG_DIR_WIDTH)
    ) u_fwd_a (
        .src_used (ex_valid & ex_uses_rs),
        .src_reg  (ex_rs),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .sel      (fwd_a)
    );

    fwd_select #(
        .REG_DIR_WIDTH (REG_DIR_WIDTH)
    ) u_fwd_b (
        .src_used (ex_valid & ex_uses_rt),
        .src_reg  (ex_rt),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .sel      (fwd_b)
    );

    assign bus.Forward_A   = fwd_a;
    assign bus.Forward_B   = fwd_b;
    assign bus.stall       = stall;
    assign bus.bubble      = bubble;
    assign bus.stall_count = stall_count_q;

endmodule
